// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC fetch into a 2-entry {pc, instr} queue,
// valid/ready delivery downstream, and redirect flush for branches/jumps.
module instr_fetch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic                  imem_re,
    input  logic [DATA_WIDTH-1:0] imem_rd,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [31:0]           fetch_count
);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [1:0]            count;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [ADDR_WIDTH-1:0] fifo_pc    [2];
    logic [DATA_WIDTH-1:0] fifo_instr [2];
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] redirect_target;

    // Redirect outranks both sides of the queue: no fetch, no delivery.
    assign inst_valid      = (count != 2'd0);
    assign pop             = inst_valid && inst_ready && !redirect_valid;
    assign push            = !redirect_valid && (!count[1] || pop);
    assign imem_re         = push && rst_n;
    assign imem_address    = {2'b00, fetch_pc[ADDR_WIDTH-1:2]};
    assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);

    assign inst_data = fifo_instr[rd_ptr];
    assign inst_pc   = fifo_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fetch_count <= 32'd0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                wr_ptr   <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr      <= ~rd_ptr;
                fetch_count <= fetch_count + 32'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else if (push) begin
            fifo_pc[wr_ptr]    <= fetch_pc;
            fifo_instr[wr_ptr] <= imem_rd;
        end
    end

endmodule
